// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over XLEN cycles, one sign-fix cycle, and early-out for div-by-zero/overflow.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            is_div,
  input  logic [1:0]      Mul_Div_unsigned,
  input  logic            is_high,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic [XLEN-1:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            stall
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_a_q, neg_b_q, div_q, high_q;

  logic              neg_a, neg_b, accept, div_zero, div_ovf;
  logic [XLEN-1:0]   mag_a, mag_b, early_result;

  assign neg_a    = ~Mul_Div_unsigned[1] & src_a[XLEN-1];
  assign neg_b    = ~Mul_Div_unsigned[0] & src_b[XLEN-1];
  assign mag_a    = neg_a ? -src_a : src_a;
  assign mag_b    = neg_b ? -src_b : src_b;
  assign accept   = (state == S_IDLE) & start & ~flush;
  assign div_zero = is_div & (src_b == '0);
  assign div_ovf  = is_div & (Mul_Div_unsigned == 2'b00)
                  & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (&src_b);

  // Division by zero wins over overflow; both bypass the iterative datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    early_result = '0;
    if (div_zero)
      early_result = is_high ? src_a : '1;
    else if (div_ovf)
      early_result = is_high ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_fit;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_fit   = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift[XLEN-1:0] - opnd;
    div_next  = {(div_fit ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_fit};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  always_comb begin
    prod_fix   = (neg_a_q ^ neg_b_q) ? -acc : acc;
    quo_fix    = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix    = neg_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_result = prod_fix[XLEN-1:0];
    if (div_q)
      fix_result = high_q ? rem_fix : quo_fix;
    else if (high_q)
      fix_result = prod_fix[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div_q   <= 1'b0;
      high_q  <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            div_q   <= is_div;
            high_q  <= is_high;
            cnt     <= '0;
            if (div_zero | div_ovf) begin
              result <= early_result;
              state  <= S_DONE;
            end else begin
              acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
              opnd  <= is_div ? mag_b : mag_a;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= div_q ? div_next : mul_next;
          if (cnt == CNT_W'(XLEN-1)) begin
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          result <= fix_result;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign result_valid = (state == S_DONE);
  assign busy         = (state == S_CALC) | (state == S_FIX);
  assign stall        = accept | busy;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: an arithmetic reference model plus a timing
// model of each operation, compared against the DUT on every cycle.
module tb_mul_div_unit;

  localparam int XLEN = 32;
  localparam int BIG  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst, start, flush, is_div, is_high;
  logic [1:0]  mdu;
  logic [31:0] src_a, src_b, result;
  logic        result_valid, busy, stall;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Current operation as seen by the bench: accept cycle, latency, flush/kill cycle, value.
  bit          op_live;
  int          t0, lat, tf;
  logic [31:0] op_val, res_base;

  mul_div_unit #(.XLEN(XLEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .flush            (flush),
    .is_div           (is_div),
    .Mul_Div_unsigned (mdu),
    .is_high          (is_high),
    .src_a            (src_a),
    .src_b            (src_b),
    .result           (result),
    .result_valid     (result_valid),
    .busy             (busy),
    .stall            (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input bit d, input bit [1:0] m, input bit h,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p, q, r;
    sa = m[1] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = m[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!d) begin
      p = sa * sb;
      return h ? p[63:32] : p[31:0];
    end
    if (b == 32'h0) begin
      q = '1;
      r = {32'b0, a};
    end else if (m == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 64'h8000_0000;
      r = '0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return h ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] exp_result(input int c);
    if (op_live && tf >= t0 + lat && c >= t0 + lat) return op_val;
    return res_base;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      bit in_flight, e_busy, e_valid, e_stall;
      in_flight = op_live && cyc > t0 && cyc <= t0 + lat && cyc <= tf;
      e_busy    = in_flight && cyc < t0 + lat;
      e_valid   = in_flight && cyc == t0 + lat;
      e_stall   = e_busy || (start && !flush && !in_flight);
      check("busy",         {31'b0, busy},         {31'b0, e_busy});
      check("result_valid", {31'b0, result_valid}, {31'b0, e_valid});
      check("stall",        {31'b0, stall},        {31'b0, e_stall});
      check("result",       result,                exp_result(cyc));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit d, input bit [1:0] m, input bit h,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input string name);
    bit early;
    start   = 1'b1;
    is_div  = d;
    mdu     = m;
    is_high = h;
    src_a   = a;
    src_b   = b;
    check({"model ", name}, model(d, m, h, a, b), lit);
    early    = d && (b == 32'h0 || (m == 2'b00 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    res_base = exp_result(cyc);
    op_val   = model(d, m, h, a, b);
    lat      = early ? 1 : XLEN + 2;
    t0       = cyc;
    tf       = BIG;
    op_live  = 1'b1;
  endtask

  task automatic run(input bit d, input bit [1:0] m, input bit h,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit, input string name);
    issue(d, m, h, a, b, lit, name);
    step(1);
    start = 1'b0;
    step(lat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; is_div = 1'b0; is_high = 1'b0;
    mdu = 2'b00; src_a = '0; src_b = '0;
    op_live = 1'b0; res_base = '0; op_val = '0; t0 = 0; lat = 0; tf = BIG;
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);

    run(1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
    run(1'b0, 2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
    run(1'b0, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
    run(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run(1'b1, 2'b00, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div");
    run(1'b1, 2'b00, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem");
    run(1'b1, 2'b11, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "divu");
    run(1'b1, 2'b11, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, "divu by 0");
    run(1'b1, 2'b11, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, "remu by 0");
    run(1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
    run(1'b1, 2'b00, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem ovf");

    // start held through DONE: ignored there, taken in the following IDLE cycle
    issue(1'b1, 2'b00, 1'b1, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, "rem by 0");
    step(1);
    step(1);
    run(1'b1, 2'b00, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf b2b");

    // flush mid-divide, then a multiply accepted the very next cycle
    issue(1'b1, 2'b00, 1'b0, 32'd100, 32'd7, 32'd14, "div flushed");
    step(1);
    start = 1'b0;
    step(9);
    flush = 1'b1;
    tf = cyc;
    step(1);
    flush = 1'b0;
    run(1'b0, 2'b00, 1'b0, 32'd123456, 32'hFFFF_FFFD, 32'hFFFA_5940, "mul after flush");

    // new operands with start during CALC must not disturb the running multiply
    issue(1'b0, 2'b11, 1'b0, 32'd1000, 32'd1000, 32'h000F_4240, "mul start ignored");
    step(1);
    start = 1'b0;
    step(4);
    start = 1'b1; is_div = 1'b1; src_a = 32'd5; src_b = 32'd6;
    step(10);
    start = 1'b0;
    step(lat - 14);

    // synchronous reset mid-operation
    issue(1'b1, 2'b11, 1'b0, 32'd1234, 32'd5, 32'h0000_00F6, "divu reset");
    step(1);
    start = 1'b0;
    step(19);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    op_live  = 1'b0;
    res_base = '0;
    step(2);

    run(1'b1, 2'b00, 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "div neg divisor");
    run(1'b1, 2'b00, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, "rem neg divisor");
    run(1'b1, 2'b11, 1'b1, 32'd100, 32'd7,         32'h0000_0002, "remu");
    run(1'b0, 2'b11, 1'b0, 32'h1234_5678, 32'h10,  32'h2345_6780, "mulu lo");
    run(1'b0, 2'b11, 1'b1, 32'h1234_5678, 32'h10,  32'h0000_0001, "mulhu small");
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
